// File: rtl/json_lexer.sv
// Streaming JSON tokenizer: byte stream in, one classified token out per handshake.
// A single output register slot holds the current token; a one-byte pending
// register and an EOF flag carry work that a byte produces beyond one token.
module json_lexer #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [3:0]       tok_type,
    output logic [LEN_W-1:0] tok_len,
    output logic [1:0]       tok_status
);

    typedef enum logic [2:0] {
        S_IDLE, S_STR, S_STR_ESC, S_NUM, S_LIT, S_DRAIN
    } state_t;

    typedef enum logic [1:0] {LIT_TRUE, LIT_FALSE, LIT_NULL} lit_t;

    localparam logic [3:0] T_LBRACE   = 4'd0;
    localparam logic [3:0] T_RBRACE   = 4'd1;
    localparam logic [3:0] T_LBRACKET = 4'd2;
    localparam logic [3:0] T_RBRACKET = 4'd3;
    localparam logic [3:0] T_COLON    = 4'd4;
    localparam logic [3:0] T_COMMA    = 4'd5;
    localparam logic [3:0] T_STRING   = 4'd6;
    localparam logic [3:0] T_NUMBER   = 4'd7;
    localparam logic [3:0] T_TRUE     = 4'd8;
    localparam logic [3:0] T_FALSE    = 4'd9;
    localparam logic [3:0] T_NULL     = 4'd10;
    localparam logic [3:0] T_EOF      = 4'd11;
    localparam logic [3:0] T_ERROR    = 4'd15;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_INVALID = 2'd1;
    localparam logic [1:0] ST_MISS    = 2'd2;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    function automatic logic is_num_char(input logic [7:0] c);
        return is_digit(c) || (c == ".") || (c == "e") || (c == "E") ||
               (c == "+") || (c == "-");
    endfunction

    // Character expected at position idx of the latched literal word.
    function automatic logic [7:0] lit_char(input lit_t kind, input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case (kind)
            LIT_TRUE: case (idx)
                3'd1: c = "r";
                3'd2: c = "u";
                3'd3: c = "e";
                default: c = 8'h00;
            endcase
            LIT_FALSE: case (idx)
                3'd1: c = "a";
                3'd2: c = "l";
                3'd3: c = "s";
                3'd4: c = "e";
                default: c = 8'h00;
            endcase
            LIT_NULL: case (idx)
                3'd1: c = "u";
                3'd2: c = "l";
                3'd3: c = "l";
                default: c = 8'h00;
            endcase
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_t           state, state_nx;
    logic [LEN_W-1:0] len, len_nx, len_inc;
    lit_t             lit_kind, kind_nx;
    logic [2:0]       lit_idx, idx_nx;
    logic             pend_valid, pend_last, eof_pend;
    logic [7:0]       pend_data;

    logic             slot_free, use_pend, use_eof, use_in, act, cur_last;
    logic [7:0]       cur;
    logic             emit, pend_set, eof_set;
    logic [3:0]       e_type;
    logic [LEN_W-1:0] e_len;
    logic [1:0]       e_status;

    // Source selection and input handshake: pending byte first, then queued EOF, then new input.
    always_comb begin
        slot_free = !tok_valid || tok_ready;
        use_pend  = pend_valid && slot_free;
        use_eof   = !pend_valid && eof_pend && slot_free;
        in_ready  = !rst && slot_free && !pend_valid && !eof_pend;
        use_in    = in_valid && in_ready;
        act       = use_pend || use_in;
        cur       = use_pend ? pend_data : in_data;
        cur_last  = use_pend ? pend_last : in_last;
        len_inc   = (len == LEN_MAX) ? len : len + 1'b1;
    end

    // Next-state and token generation for the byte being processed this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_nx = state;
        len_nx   = len;
        kind_nx  = lit_kind;
        idx_nx   = lit_idx;
        emit     = 1'b0;
        e_type   = T_LBRACE;
        e_len    = '0;
        e_status = ST_OK;
        pend_set = 1'b0;
        eof_set  = 1'b0;

        if (use_eof) begin
            emit   = 1'b1;
            e_type = T_EOF;
        end else if (act) begin
            case (state)
                S_IDLE: begin
                    case (cur)
                        " ", 8'h09, 8'h0D, 8'h0A: ;
                        "{": begin emit = 1'b1; e_type = T_LBRACE;   end
                        "}": begin emit = 1'b1; e_type = T_RBRACE;   end
                        "[": begin emit = 1'b1; e_type = T_LBRACKET; end
                        "]": begin emit = 1'b1; e_type = T_RBRACKET; end
                        ":": begin emit = 1'b1; e_type = T_COLON;    end
                        ",": begin emit = 1'b1; e_type = T_COMMA;    end
                        "\"": begin
                            state_nx = S_STR;
                            len_nx   = '0;
                        end
                        "t", "f", "n": begin
                            state_nx = S_LIT;
                            kind_nx  = (cur == "t") ? LIT_TRUE :
                                       (cur == "f") ? LIT_FALSE : LIT_NULL;
                            idx_nx   = 3'd1;
                            len_nx   = LEN_W'(1);
                        end
                        default: begin
                            if (cur == "-" || is_digit(cur)) begin
                                state_nx = S_NUM;
                                len_nx   = LEN_W'(1);
                            end else begin
                                emit     = 1'b1;
                                e_type   = T_ERROR;
                                e_status = ST_INVALID;
                                state_nx = S_DRAIN;
                            end
                        end
                    endcase
                end
                S_STR: begin
                    if (cur == "\"") begin
                        emit     = 1'b1;
                        e_type   = T_STRING;
                        e_len    = len;
                        state_nx = S_IDLE;
                    end else begin
                        len_nx = len_inc;
                        if (cur == "\\") state_nx = S_STR_ESC;
                    end
                end
                S_STR_ESC: begin
                    len_nx   = len_inc;
                    state_nx = S_STR;
                end
                S_NUM: begin
                    if (is_num_char(cur)) begin
                        len_nx = len_inc;
                    end else begin
                        // Terminator is kept and re-run through IDLE on the next cycle.
                        emit     = 1'b1;
                        e_type   = T_NUMBER;
                        e_len    = len;
                        pend_set = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_LIT: begin
                    if (cur == lit_char(lit_kind, lit_idx)) begin
                        len_nx = len_inc;
                        idx_nx = lit_idx + 1'b1;
                        if (lit_idx == ((lit_kind == LIT_FALSE) ? 3'd4 : 3'd3)) begin
                            emit     = 1'b1;
                            e_type   = (lit_kind == LIT_TRUE)  ? T_TRUE :
                                       (lit_kind == LIT_FALSE) ? T_FALSE : T_NULL;
                            e_len    = len_inc;
                            state_nx = S_IDLE;
                        end
                    end else begin
                        emit     = 1'b1;
                        e_type   = T_ERROR;
                        e_status = ST_INVALID;
                        state_nx = S_DRAIN;
                    end
                end
                S_DRAIN: ;
                default: state_nx = S_IDLE;
            endcase

            // End of document: settle whatever state the final byte left behind.
            if (cur_last && !pend_set) begin
                if (emit && e_type == T_ERROR) begin
                    state_nx = S_IDLE;
                end else begin
                    case (state_nx)
                        S_IDLE: begin
                            if (emit) begin
                                eof_set = 1'b1;
                            end else begin
                                emit   = 1'b1;
                                e_type = T_EOF;
                            end
                        end
                        S_STR, S_STR_ESC: begin
                            emit     = 1'b1;
                            e_type   = T_ERROR;
                            e_status = ST_MISS;
                            state_nx = S_IDLE;
                        end
                        S_LIT: begin
                            emit     = 1'b1;
                            e_type   = T_ERROR;
                            e_status = ST_INVALID;
                            state_nx = S_IDLE;
                        end
                        S_NUM: begin
                            emit     = 1'b1;
                            e_type   = T_NUMBER;
                            e_len    = len_nx;
                            eof_set  = 1'b1;
                            state_nx = S_IDLE;
                        end
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
        end
    end

    // State, length, literal tracking, pending byte and EOF flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            len        <= '0;
            lit_kind   <= LIT_TRUE;
            lit_idx    <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_last  <= 1'b0;
            eof_pend   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state    <= state_nx;
            len      <= len_nx;
            lit_kind <= kind_nx;
            lit_idx  <= idx_nx;
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_data  <= cur;
                pend_last  <= cur_last;
            end else if (use_pend) begin
                pend_valid <= 1'b0;
            end
            if (eof_set)      eof_pend <= 1'b1;
            else if (use_eof) eof_pend <= 1'b0;
        end
    end

    // Output slot: reload on a new token, otherwise clear once taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_valid  <= 1'b0;
            tok_type   <= '0;
            tok_len    <= '0;
            tok_status <= '0;
        end else if (emit) begin
            tok_valid  <= 1'b1;
            tok_type   <= e_type;
            tok_len    <= e_len;
            tok_status <= e_status;
        end else if (tok_ready) begin
            tok_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_json_lexer.sv
// Directed testbench for json_lexer: feeds documents byte by byte, collects
// handshaken tokens and compares them against hand-computed sequences.
module tb_json_lexer;

    localparam int LEN_W = 4;

    typedef struct packed {
        logic [3:0]       t;
        logic [LEN_W-1:0] l;
        logic [1:0]       s;
    } tok_rec_t;

    logic             clk, rst;
    logic             in_valid, in_ready, in_last;
    logic [7:0]       in_data;
    logic             tok_valid, tok_ready;
    logic [3:0]       tok_type;
    logic [LEN_W-1:0] tok_len;
    logic [1:0]       tok_status;

    tok_rec_t got_q[$];
    int  n_asserts = 0;
    int  n_fail    = 0;
    int  stalls    = 0;
    logic acc, rdy_s;

    json_lexer #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_type   (tok_type),
        .tok_len    (tok_len),
        .tok_status (tok_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven at the falling edge; sample the coming handshake 1 time unit later.
    task automatic cycle();
        #1;
        if (tok_valid && tok_ready) got_q.push_back('{tok_type, tok_len, tok_status});
        acc   = in_valid && in_ready;
        rdy_s = in_ready;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            cycle();
            if (!acc) stalls++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check("send timeout", acc, 1);
    endtask

    task automatic send_str(input string s, input logic last_at_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_at_end && (i == s.len() - 1));
    endtask

    task automatic expect_tok(input string tag, input logic [3:0] t,
                              input int l, input logic [1:0] s);
        tok_rec_t r;
        tok_rec_t e;
        r = (got_q.size() > 0) ? got_q.pop_front() : '1;
        e = '{t, LEN_W'(l), s};
        check(tag, r, e);
    endtask

    task automatic expect_empty(input string tag);
        check(tag, got_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; tok_ready = 1'b1;
        @(negedge clk); #1;
        check("reset tok_valid", tok_valid, 0);
        check("reset tok_type", tok_type, 0);
        check("reset tok_len", tok_len, 0);
        check("reset tok_status", tok_status, 0);
        check("reset in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post-reset in_ready", in_ready, 1);
        @(negedge clk);

        // Object with string key and number value.
        stalls = 0;
        send_str("{\"ab\":12}", 1'b1);
        check("obj stalls", stalls, 0);
        cycle();
        check("obj in_ready after }", rdy_s, 0);
        idle(8);
        expect_tok("obj lbrace", 4'd0, 0, 2'd0);
        expect_tok("obj string", 4'd6, 2, 2'd0);
        expect_tok("obj colon", 4'd4, 0, 2'd0);
        expect_tok("obj number", 4'd7, 2, 2'd0);
        expect_tok("obj rbrace", 4'd1, 0, 2'd0);
        expect_tok("obj eof", 4'd11, 0, 2'd0);
        expect_empty("obj extra");

        // Array of literals with whitespace.
        send_str(" [true, null ,false]", 1'b1);
        idle(8);
        expect_tok("lit lbracket", 4'd2, 0, 2'd0);
        expect_tok("lit true", 4'd8, 4, 2'd0);
        expect_tok("lit comma1", 4'd5, 0, 2'd0);
        expect_tok("lit null", 4'd10, 4, 2'd0);
        expect_tok("lit comma2", 4'd5, 0, 2'd0);
        expect_tok("lit false", 4'd9, 5, 2'd0);
        expect_tok("lit rbracket", 4'd3, 0, 2'd0);
        expect_tok("lit eof", 4'd11, 0, 2'd0);
        expect_empty("lit extra");

        // Unterminated string with an escape, then a clean one-byte document.
        send_str("\"a\\\"b", 1'b1);
        idle(6);
        expect_tok("unterm error", 4'd15, 0, 2'd2);
        expect_empty("unterm no eof");
        send_str("1", 1'b1);
        idle(6);
        expect_tok("one number", 4'd7, 1, 2'd0);
        expect_tok("one eof", 4'd11, 0, 2'd0);
        expect_empty("one extra");

        // Broken literal, remainder drained.
        send_str("tru x", 1'b1);
        idle(6);
        expect_tok("badlit error", 4'd15, 0, 2'd1);
        expect_empty("badlit drained");

        // Invalid start byte on the final byte: error, no EOF.
        send_str("@", 1'b1);
        idle(6);
        expect_tok("badbyte error", 4'd15, 0, 2'd1);
        expect_empty("badbyte no eof");

        // Number with all number characters, terminated by whitespace on last byte.
        send_str("-1.5e+3 ", 1'b1);
        idle(6);
        expect_tok("num long", 4'd7, 7, 2'd0);
        expect_tok("num eof", 4'd11, 0, 2'd0);
        expect_empty("num extra");

        // Length saturation (LEN_W=4 caps at 15).
        send_str("\"aaaaaaaaaaaaaaaaaaaa\"", 1'b1);
        idle(6);
        expect_tok("sat string", 4'd6, 15, 2'd0);
        expect_tok("sat eof", 4'd11, 0, 2'd0);

        // Backpressure: hold the first token for 5 cycles.
        send_str("[", 1'b0);
        tok_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = "1";
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp tok_valid", tok_valid, 1);
            check("bp tok_type", tok_type, 2);
            check("bp in_ready", rdy_s, 0);
        end
        tok_ready = 1'b1;
        send_str("1,2]", 1'b1);
        idle(8);
        expect_tok("bp lbracket", 4'd2, 0, 2'd0);
        expect_tok("bp num1", 4'd7, 1, 2'd0);
        expect_tok("bp comma", 4'd5, 0, 2'd0);
        expect_tok("bp num2", 4'd7, 1, 2'd0);
        expect_tok("bp rbracket", 4'd3, 0, 2'd0);
        expect_tok("bp eof", 4'd11, 0, 2'd0);
        expect_empty("bp extra");

        // Reset while a token sits in the slot.
        tok_ready = 1'b0;
        send_str("{", 1'b0);
        cycle();
        check("held before reset", tok_valid, 1);
        rst = 1'b1;
        #1 check("held cleared by reset", tok_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tok_ready = 1'b1;
        @(negedge clk);

        // Reset mid-string; next document must lex from IDLE.
        send_str("\"abc", 1'b0);
        rst = 1'b1;
        #1 check("midstr tok_valid", tok_valid, 0);
        check("midstr in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_q.delete();
        send_str(",", 1'b1);
        idle(6);
        expect_tok("rst comma", 4'd5, 0, 2'd0);
        expect_tok("rst eof", 4'd11, 0, 2'd0);
        expect_empty("rst extra");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
